// File: rtl/counter_pkg.sv
// Shared types and constants for the counter scheduler.
package counter_pkg;

    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2,
        HOLD = 2'd3
    } sched_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_sched_if.sv
// Requester and counter-pin bundle between the scheduler (slave) and its environment (master).
interface counter_sched_if import counter_pkg::*; #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = CNT_W
);
    localparam int unsigned IW = idx_w(N_REQ);

    logic               run;
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] req_data;
    logic [N_REQ-1:0]   ack;
    logic [W-1:0]       cnt_count;
    logic               cnt_enable;
    logic               cnt_load;
    logic [W-1:0]       cnt_data;
    logic [IW-1:0]      grant_id;
    logic               busy;
    logic               wrap;

    modport master (
        output run, req, req_data, cnt_count,
        input  ack, cnt_enable, cnt_load, cnt_data, grant_id, busy, wrap
    );

    modport slave (
        input  run, req, req_data, cnt_count,
        output ack, cnt_enable, cnt_load, cnt_data, grant_id, busy, wrap
    );

endinterface

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational request arbiter: round-robin from ptr, or lowest-index-wins when
// CNT_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter import counter_pkg::*; #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant_c,
    output logic [IW-1:0]    idx_c,
    output logic             valid_c
);

`ifdef CNT_SCHED_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    // First requester found walking upward from the search start wins.
    always_comb begin
        int          j;
        logic [IW-1:0] j_idx;
        grant_c = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        j       = 0;
        j_idx   = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
`ifdef CNT_SCHED_FIXED_PRIO_EN
            j = k;
`else
            j = (k + int'(ptr)) % int'(N_REQ);
`endif
            j_idx = IW'(j);
            if (!valid_c && req[j_idx]) begin
                valid_c        = 1'b1;
                grant_c[j_idx] = 1'b1;
                idx_c          = j_idx;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Sequences enable/load of a loadable counter and shares its load port among requesters.
// Arbitration policy selected inside rr_arbiter by CNT_SCHED_FIXED_PRIO_EN.
module counter_sched import counter_pkg::*; #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned W           = CNT_W,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    counter_sched_if.slave bus
);

    localparam int unsigned IW = idx_w(N_REQ);
    localparam int unsigned HW = idx_w(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;

    sched_state_t     state, state_next;
    logic [IW-1:0]    ptr, ptr_d;
    logic [HW-1:0]    hold_cnt, hold_d;
    logic [N_REQ-1:0] arb_grant;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;
    logic [W-1:0]     sel_data;

    logic             enable_d, load_d, busy_d, wrap_d;
    logic [N_REQ-1:0] ack_d;
    logic [W-1:0]     data_d;
    logic [IW-1:0]    gid_d;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .grant_c (arb_grant),
        .idx_c   (arb_idx),
        .valid_c (arb_valid)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (arb_grant[i]) sel_data = bus.req_data[i*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A request pending as HOLD expires goes straight to LOAD, so back-to-back grants are 1+HOLD_CYCLES apart.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (arb_valid)    state_next = LOAD;
                else if (bus.run) state_next = RUN;
            end
            RUN: begin
                if (arb_valid)     state_next = LOAD;
                else if (!bus.run) state_next = IDLE;
            end
            LOAD: begin
                if (HOLD_CYCLES > 0) state_next = HOLD;
                else                 state_next = bus.run ? RUN : IDLE;
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    if (arb_valid) state_next = LOAD;
                    else           state_next = bus.run ? RUN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed off the state being entered.
    always_comb begin
        enable_d = (state_next == RUN);
        load_d   = (state_next == LOAD);
        busy_d   = (state_next == LOAD) || (state_next == HOLD);
        ack_d    = load_d ? arb_grant : '0;
        wrap_d   = bus.cnt_enable && (bus.cnt_count == '1) && (state_next != LOAD);
        data_d   = bus.cnt_data;
        gid_d    = bus.grant_id;
        ptr_d    = ptr;
        hold_d   = hold_cnt;
        if (load_d) begin
            data_d = sel_data;
            gid_d  = arb_idx;
            ptr_d  = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
            hold_d = HOLD_INIT;
        end else if (state == HOLD && hold_cnt != '0) begin
            hold_d = hold_cnt - HW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cnt_enable <= 1'b0;
            bus.cnt_load   <= 1'b0;
            bus.cnt_data   <= '0;
            bus.ack        <= '0;
            bus.grant_id   <= '0;
            bus.busy       <= 1'b0;
            bus.wrap       <= 1'b0;
            ptr            <= '0;
            hold_cnt       <= '0;
        end else begin
            bus.cnt_enable <= enable_d;
            bus.cnt_load   <= load_d;
            bus.cnt_data   <= data_d;
            bus.ack        <= ack_d;
            bus.grant_id   <= gid_d;
            bus.busy       <= busy_d;
            bus.wrap       <= wrap_d;
            ptr            <= ptr_d;
            hold_cnt       <= hold_d;
        end
    end

endmodule
